// File: rtl/puf_response_collector.sv
// Sequencer for the 64-RO arbiter PUF core: clears, arms and races the core
// once per challenge bit, then assembles the NUM_BITS response word.
module puf_response_collector #(
  parameter int unsigned NUM_BITS       = 64,
  parameter int unsigned STRIDE         = 33,
  parameter int unsigned CLEAR_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [9:0]          seed_challenge,
  input  logic                cnt1_finish,
  input  logic                cnt2_finish,
  input  logic                cnt1_led,
  output logic [9:0]          challenge,
  output logic [63:0]         ro_enable,
  output logic                puf_clear,
  output logic [NUM_BITS-1:0] response,
  output logic                response_valid,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned KW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int unsigned CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [CW-1:0] clr_cnt;
  logic [TW-1:0] tmo_cnt;

  // Two-flop synchronisers, packed as {led, finish2, finish1}
  logic [2:0] sync_meta;
  logic [2:0] sync_q;
  logic       f1s;
  logic       f2s;
  logic       l1s;

  logic [63:0] arm_mask;
  logic        race_done;
  logic        race_bit;
  logic        tmo_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 3'b000;
      sync_q    <= 3'b000;
    end else begin
      sync_meta <= {cnt1_led, cnt2_finish, cnt1_finish};
      sync_q    <= sync_meta;
    end
  end

  assign f1s = sync_q[0];
  assign f2s = sync_q[1];
  assign l1s = sync_q[2];

  // Counter gate plus one RO from each mux bank; coinciding indices just overlap
  always_comb begin
    arm_mask = 64'd1;
    arm_mask[{1'b0, challenge[4:0]}] = 1'b1;
    arm_mask[{1'b1, challenge[9:5]}] = 1'b1;
  end

  // A simultaneous finish is resolved by the counter-compare LED
  always_comb begin
    race_done = f1s | f2s;
    race_bit  = (f1s & f2s) ? l1s : f1s;
    tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      k              <= '0;
      clr_cnt        <= '0;
      tmo_cnt        <= '0;
      challenge      <= 10'd0;
      ro_enable      <= 64'd0;
      puf_clear      <= 1'b1;
      response       <= '0;
      response_valid <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      response_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          puf_clear <= 1'b1;
          ro_enable <= 64'd0;
          if (start) begin
            challenge   <= seed_challenge;
            k           <= '0;
            clr_cnt     <= '0;
            response    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            state       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          puf_clear <= 1'b1;
          ro_enable <= 64'd0;
          if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
            state <= S_ARM;
          end else begin
            clr_cnt <= clr_cnt + CW'(1);
          end
        end
        S_ARM: begin
          puf_clear <= 1'b0;
          ro_enable <= arm_mask;
          tmo_cnt   <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (race_done) begin
            response[k] <= race_bit;
            ro_enable   <= 64'd0;
            state       <= S_NEXT;
          end else if (tmo_hit) begin
            response[k] <= 1'b0;
            timeout_err <= 1'b1;
            ro_enable   <= 64'd0;
            state       <= S_NEXT;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_NEXT: begin
          puf_clear <= 1'b1;
          if (k == KW'(NUM_BITS - 1)) begin
            response_valid <= 1'b1;
            state          <= S_DONE;
          end else begin
            k         <= k + KW'(1);
            challenge <= challenge + 10'(STRIDE);
            clr_cnt   <= '0;
            state     <= S_CLEAR;
          end
        end
        S_DONE: begin
          puf_clear <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_response_collector.sv
// Scoreboard bench for puf_response_collector: a behavioural core model drives
// the finish races while a monitor checks challenges, wait lengths and responses.
module tb_puf_response_collector;

  localparam int unsigned NB  = 5;
  localparam int unsigned TMO = 100;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [9:0]    seed_challenge;
  logic          cnt1_finish = 1'b0;
  logic          cnt2_finish = 1'b0;
  logic          cnt1_led    = 1'b0;
  logic [9:0]    challenge;
  logic [63:0]   ro_enable;
  logic          puf_clear;
  logic [NB-1:0] response;
  logic          response_valid;
  logic          busy;
  logic          timeout_err;

  puf_response_collector #(
    .NUM_BITS       (NB),
    .STRIDE         (33),
    .CLEAR_CYCLES   (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .seed_challenge (seed_challenge),
    .cnt1_finish    (cnt1_finish),
    .cnt2_finish    (cnt2_finish),
    .cnt1_led       (cnt1_led),
    .challenge      (challenge),
    .ro_enable      (ro_enable),
    .puf_clear      (puf_clear),
    .response       (response),
    .response_valid (response_valid),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct { logic [9:0] chal; bit tmo; } chal_exp_t;
  typedef struct { logic [NB-1:0] resp; logic terr; } resp_exp_t;

  chal_exp_t exp_chal[$];
  resp_exp_t exp_resp[$];
  int        n_cmp   = 0;
  int        n_fail  = 0;
  int        n_valid = 0;
  // Per-bit core behaviour: 0 fin1 wins, 1 fin2 wins, 2 both with led high, 3 none
  int        modes [NB];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_chal(input logic [9:0] c, input bit tmo);
    chal_exp_t e;
    e.chal = c;
    e.tmo  = tmo;
    exp_chal.push_back(e);
  endtask

  task automatic push_resp(input logic [NB-1:0] r, input logic terr);
    resp_exp_t e;
    e.resp = r;
    e.terr = terr;
    exp_resp.push_back(e);
  endtask

  // Core model: finishes drop while cleared and rise a few cycles into each race
  int   bit_idx  = 0;
  int   wcnt     = 0;
  int   cur_mode = 0;
  logic en_q     = 1'b0;

  always @(negedge clock) begin
    if (!busy) bit_idx = 0;
    if (puf_clear) begin
      cnt1_finish = 1'b0;
      cnt2_finish = 1'b0;
      cnt1_led    = 1'b0;
    end else if (ro_enable[0]) begin
      if (!en_q) begin
        cur_mode = modes[bit_idx % NB];
        bit_idx++;
        wcnt = 0;
      end
      wcnt++;
      if (wcnt == 3) begin
        case (cur_mode)
          0: cnt1_finish = 1'b1;
          1: cnt2_finish = 1'b1;
          2: begin
            cnt1_finish = 1'b1;
            cnt2_finish = 1'b1;
            cnt1_led    = 1'b1;
          end
          default: ;
        endcase
      end
    end
    en_q = ro_enable[0];
  end

  // Monitor: pops expectations whenever the DUT starts a race or presents a response
  logic      mon_en_q = 1'b0;
  int        wlen     = 0;
  chal_exp_t cur;
  resp_exp_t r;

  initial cur.tmo = 1'b0;

  always @(negedge clock) begin
    if (ro_enable[0] && !mon_en_q) begin
      wlen = 0;
      if (exp_chal.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_race: challenge %h with nothing expected", challenge);
      end else begin
        cur = exp_chal.pop_front();
        chk("challenge", 64'(challenge), 64'(cur.chal));
      end
    end
    if (ro_enable[0]) wlen++;
    if (!ro_enable[0] && mon_en_q && cur.tmo) begin
      chk("timeout_wait_len", 64'(wlen), 64'(TMO));
      cur.tmo = 1'b0;
    end
    mon_en_q = ro_enable[0];
    if (response_valid) begin
      n_valid++;
      if (exp_resp.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_response_valid: response %h with no run pending", response);
      end else begin
        r = exp_resp.pop_front();
        chk("response", 64'(response), 64'(r.resp));
        chk("timeout_err", 64'(timeout_err), 64'(r.terr));
        chk("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic start_run(input logic [9:0] seed);
    seed_challenge = seed;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: busy still high after %0d cycles", name, n);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_challenge"}, 64'(challenge), 64'd0);
    chk({tag, "_ro_enable"}, ro_enable, 64'd0);
    chk({tag, "_puf_clear"}, 64'(puf_clear), 64'd1);
    chk({tag, "_response"}, 64'(response), 64'd0);
    chk({tag, "_response_valid"}, 64'(response_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    seed_challenge = 10'h155;
    modes = '{0, 0, 0, 0, 0};
    repeat (3) @(negedge clock);
    check_reset_values("rst");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    chk("start_with_reset_busy", 64'(busy), 64'd0);

    // Run 1: fin1 always wins
    modes = '{0, 0, 0, 0, 0};
    push_chal(10'h005, 0); push_chal(10'h026, 0); push_chal(10'h047, 0);
    push_chal(10'h068, 0); push_chal(10'h089, 0);
    push_resp(5'b11111, 1'b0);
    start_run(10'h005);
    chk("r1_busy", 64'(busy), 64'd1);
    chk("r1_clear_ro_enable", ro_enable, 64'd0);
    chk("r1_clear_puf_clear", 64'(puf_clear), 64'd1);
    wait_idle("r1_done");
    repeat (3) @(negedge clock);
    chk("r1_response_hold", 64'(response), 64'h1F);

    // Run 2: RO enable mask for mux1=7, mux2=31, with challenge wrap later in run
    push_chal(10'h3E7, 0); push_chal(10'h008, 0); push_chal(10'h029, 0);
    push_chal(10'h04A, 0); push_chal(10'h06B, 0);
    push_resp(5'b11111, 1'b0);
    start_run(10'h3E7);
    chk("r2_clear_ro_enable", ro_enable, 64'd0);
    for (int i = 0; i < 50 && !ro_enable[0]; i++) @(negedge clock);
    chk("r2_wait_ro_enable", ro_enable, 64'h8000_0000_0000_0081);
    chk("r2_wait_puf_clear", 64'(puf_clear), 64'd0);
    wait_idle("r2_done");

    // Run 3: alternating winners, simultaneous finish resolved by led
    modes = '{1, 0, 1, 0, 2};
    push_chal(10'h000, 0); push_chal(10'h021, 0); push_chal(10'h042, 0);
    push_chal(10'h063, 0); push_chal(10'h084, 0);
    push_resp(5'b11010, 1'b0);
    start_run(10'h000);
    wait_idle("r3_done");

    // Run 4: bit 2 never finishes and is forced after the timeout
    modes = '{0, 0, 3, 0, 0};
    push_chal(10'h100, 0); push_chal(10'h121, 0); push_chal(10'h142, 1);
    push_chal(10'h163, 0); push_chal(10'h184, 0);
    push_resp(5'b11011, 1'b1);
    start_run(10'h100);
    wait_idle("r4_done");
    repeat (2) @(negedge clock);
    chk("r4_timeout_err_sticky", 64'(timeout_err), 64'd1);

    // Run 5: wrap from 0x3F0, timeout_err cleared by the new start
    modes = '{0, 0, 0, 0, 0};
    push_chal(10'h3F0, 0); push_chal(10'h011, 0); push_chal(10'h032, 0);
    push_chal(10'h053, 0); push_chal(10'h074, 0);
    push_resp(5'b11111, 1'b0);
    start_run(10'h3F0);
    chk("r5_timeout_err_cleared", 64'(timeout_err), 64'd0);
    chk("r5_response_cleared", 64'(response), 64'd0);
    wait_idle("r5_done");

    // Run 6: a start pulse while busy must not restart the run
    push_chal(10'h005, 0); push_chal(10'h026, 0); push_chal(10'h047, 0);
    push_chal(10'h068, 0); push_chal(10'h089, 0);
    push_resp(5'b11111, 1'b0);
    start_run(10'h005);
    repeat (8) @(negedge clock);
    start_run(10'h2AA);
    wait_idle("r6_done");
    repeat (20) @(negedge clock);
    chk("r6_no_restart_busy", 64'(busy), 64'd0);
    chk("r6_valid_count", 64'(n_valid), 64'd6);

    // Run 7: reset while bit 2 is racing discards the partial response
    modes = '{0, 0, 3, 0, 0};
    push_chal(10'h200, 0); push_chal(10'h221, 0); push_chal(10'h242, 0);
    start_run(10'h200);
    for (int i = 0; i < 200 && bit_idx < 3; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    chk("r7_partial_response", 64'(response), 64'h03);
    chk("r7_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("mid_rst");
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("r7_idle_after_reset", 64'(busy), 64'd0);

    chk("chal_queue_drained", 64'(exp_chal.size()), 64'd0);
    chk("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
    chk("total_valid_pulses", 64'(n_valid), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
